// File: rtl/icache_resp_if.sv
// Fetch-side and memory-side signals of the instruction-cache responder.
// The slave modport is the cache view; the master modport is the view of the
// fetch stage, flow control and memory bus that surround it.
interface icache_resp_if;
  logic        if_req_i;
  logic [31:0] if_pc_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        inst_vld_o;
  logic        stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  modport slave (
    input  if_req_i, if_pc_i, flush_i, mem_ack_i, mem_data_i,
    output inst_o, inst_vld_o, stall_o, mem_req_o, mem_addr_o
  );

  modport master (
    output if_req_i, if_pc_i, flush_i, mem_ack_i, mem_data_i,
    input  inst_o, inst_vld_o, stall_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/icache_resp.sv
// Direct-mapped, read-only instruction cache responder.
// A hit returns the addressed word one cycle after the request. A miss raises
// stall_o, fetches the whole line over the mem req/ack beat interface, then
// validates the line so the replayed request hits.
// Optional build macro ICACHE_PERF_EN adds hit/miss counters (hit_cnt_o,
// miss_cnt_o); without it those ports and counters do not exist.
module icache_resp #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef ICACHE_PERF_EN
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o,
`endif
  icache_resp_if.slave bus
);

  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int OB = WB + 2;
  localparam int TB = 32 - OB - IB;

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  state_t           state;
  logic [LINES-1:0] valid;
  logic [TB-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];

  logic [IB-1:0]    fill_idx;
  logic [TB-1:0]    fill_tag;
  logic [WB-1:0]    beat;
  logic             flush_pend;

  logic [IB-1:0]    req_idx;
  logic [TB-1:0]    req_tag;
  logic [WB-1:0]    req_word;
  logic             hit;
  logic             hit_resp;
  logic             miss_start;
  logic             beat_wr;
  logic             unused_pc_bits;

  assign req_idx  = bus.if_pc_i[OB +: IB];
  assign req_tag  = bus.if_pc_i[31 -: TB];
  assign req_word = bus.if_pc_i[2 +: WB];
  assign unused_pc_bits = ^bus.if_pc_i[1:0];

  // A flush in the same cycle as a request forces the miss path
  assign hit        = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !bus.flush_i;
  assign hit_resp   = (state == IDLE) && bus.if_req_i && hit;
  assign miss_start = (state == IDLE) && bus.if_req_i && !hit;
  assign beat_wr    = (state == REFILL) && bus.mem_ack_i;

  // Data and tag arrays: refill beats land at word[beat], tag written in DONE
  always_ff @(posedge clk) begin
    if (beat_wr) begin
      data_mem[{fill_idx, beat}] <= bus.mem_data_i;
    end
    if (state == DONE) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

  // Lookup/refill state machine with registered responses and valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      valid          <= '0;
      fill_idx       <= '0;
      fill_tag       <= '0;
      beat           <= '0;
      flush_pend     <= 1'b0;
      bus.inst_o     <= '0;
      bus.inst_vld_o <= 1'b0;
      bus.stall_o    <= 1'b0;
      bus.mem_req_o  <= 1'b0;
      bus.mem_addr_o <= '0;
    end else begin
      bus.inst_vld_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.flush_i) begin
            valid <= '0;
          end
          if (hit_resp) begin
            bus.inst_o     <= data_mem[{req_idx, req_word}];
            bus.inst_vld_o <= 1'b1;
          end else if (miss_start) begin
            // The victim line is dropped now so a pending flush leaves it invalid
            valid[req_idx] <= 1'b0;
            fill_idx       <= req_idx;
            fill_tag       <= req_tag;
            beat           <= '0;
            flush_pend     <= 1'b0;
            bus.stall_o    <= 1'b1;
            bus.mem_req_o  <= 1'b1;
            bus.mem_addr_o <= {bus.if_pc_i[31:OB], {OB{1'b0}}};
            state          <= REFILL;
          end
        end
        REFILL: begin
          if (bus.flush_i) begin
            valid      <= '0;
            flush_pend <= 1'b1;
          end
          if (bus.mem_ack_i) begin
            beat <= beat + WB'(1);
            if (beat == WB'(WORDS - 1)) begin
              bus.mem_req_o <= 1'b0;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.flush_i) begin
            valid <= '0;
          end else if (!flush_pend) begin
            valid[fill_idx] <= 1'b1;
          end
          flush_pend  <= 1'b0;
          bus.stall_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  // Hit/miss counters; a flush clears them but still counts a miss it triggers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (bus.flush_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= {31'b0, miss_start};
    end else begin
      hit_cnt_o  <= hit_cnt_o + {31'b0, hit_resp};
      miss_cnt_o <= miss_cnt_o + {31'b0, miss_start};
    end
  end
`endif

endmodule

// File: tb/tb_icache_resp.sv
// Self-checking bench for icache_resp. The reference model tracks only which
// lines are valid and their tags; a valid line always holds what the memory
// image holds, so expected words come straight from that image.
module tb_icache_resp;
  localparam int LINES      = 64;
  localparam int WORDS      = 4;
  localparam int LINE_BYTES = WORDS * 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  icache_resp_if bus();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_resp #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ICACHE_PERF_EN
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  bit          model_valid [LINES];
  logic [31:0] model_tag   [LINES];
  logic [31:0] mem_img     [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    if (mem_img.exists(wa)) return mem_img[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc / LINE_BYTES) % LINES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (LINE_BYTES * LINES);
  endfunction

  task automatic model_clear();
    foreach (model_valid[i]) model_valid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serves one line refill; random or fixed gaps between beats, optional flush on a beat
  task automatic refill(input logic [31:0] base, input int flush_beat, input int gap,
                        output bit flushed);
    int d;
    bit exp_req;
    flushed = 1'b0;
    for (int b = 0; b < WORDS; b++) begin
      d = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < d; k++) begin
        bus.if_req_i   = 1'($urandom_range(0, 1));
        bus.if_pc_i    = $urandom;
        bus.mem_data_i = $urandom;
        step();
        bus.if_req_i = 1'b0;
        vectors++;
        if (bus.mem_req_o !== 1'b1 || bus.stall_o !== 1'b1 || bus.inst_vld_o !== 1'b0 ||
            bus.mem_addr_o !== base)
          begin
            miscompares++;
            $display("[TB] FAIL refill_hold beat %0d: req=%b stall=%b vld=%b addr=%h, need 1 1 0 %h",
                     b, bus.mem_req_o, bus.stall_o, bus.inst_vld_o, bus.mem_addr_o, base);
          end
      end
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = mem_word(base + 32'(4 * b));
      bus.flush_i    = (b == flush_beat);
      if (b == flush_beat) flushed = 1'b1;
      step();
      bus.mem_ack_i = 1'b0;
      bus.flush_i   = 1'b0;
      exp_req = (b < WORDS - 1);
      vectors++;
      if (bus.mem_req_o !== exp_req || bus.stall_o !== 1'b1 || bus.mem_addr_o !== base) begin
        miscompares++;
        $display("[TB] FAIL refill_beat %0d: req=%b stall=%b addr=%h, need %b 1 %h",
                 b, bus.mem_req_o, bus.stall_o, bus.mem_addr_o, exp_req, base);
      end
    end
    step();
    vectors++;
    if (bus.stall_o !== 1'b0 || bus.mem_req_o !== 1'b0 || bus.inst_vld_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL refill_done: stall=%b req=%b vld=%b, need 0 0 0",
               bus.stall_o, bus.mem_req_o, bus.inst_vld_o);
    end
    if (flushed) model_clear();
  endtask

  // Requests pc until it hits, servicing each miss the model predicts
  task automatic do_access(input logic [31:0] pc, input bit flush, input int flush_beat,
                           input int gap);
    bit          exp_hit;
    bit          fl;
    bit          flushed;
    int          idx;
    logic [31:0] base;
    idx  = line_of(pc);
    base = pc & ~32'(LINE_BYTES - 1);
    for (int attempt = 0; attempt < 3; attempt++) begin
      fl = (attempt == 0) && flush;
      if (fl) model_clear();
      exp_hit = model_valid[idx] && (model_tag[idx] == tag_of(pc));
      bus.if_req_i = 1'b1;
      bus.if_pc_i  = pc;
      bus.flush_i  = fl;
      step();
      bus.if_req_i = 1'b0;
      bus.flush_i  = 1'b0;
      if (exp_hit) begin
        vectors++;
        if (bus.inst_vld_o !== 1'b1 || bus.inst_o !== mem_word(pc)) begin
          miscompares++;
          $display("[TB] FAIL hit pc=%h: vld=%b inst=%h, need 1 %h",
                   pc, bus.inst_vld_o, bus.inst_o, mem_word(pc));
        end
        break;
      end
      vectors++;
      if (bus.inst_vld_o !== 1'b0 || bus.stall_o !== 1'b1 || bus.mem_req_o !== 1'b1 ||
          bus.mem_addr_o !== base)
        begin
          miscompares++;
          $display("[TB] FAIL miss pc=%h: vld=%b stall=%b req=%b addr=%h, need 0 1 1 %h",
                   pc, bus.inst_vld_o, bus.stall_o, bus.mem_req_o, bus.mem_addr_o, base);
        end
      refill(base, (attempt == 0) ? flush_beat : -1, gap, flushed);
      if (!flushed) begin
        model_valid[idx] = 1'b1;
        model_tag[idx]   = tag_of(pc);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (bus.inst_o !== 32'h0 || bus.inst_vld_o !== 1'b0 || bus.stall_o !== 1'b0 ||
        bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h0)
      begin
        miscompares++;
        $display("[TB] FAIL reset_outputs: inst=%h vld=%b stall=%b req=%b addr=%h, need all 0",
                 bus.inst_o, bus.inst_vld_o, bus.stall_o, bus.mem_req_o, bus.mem_addr_o);
      end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    model_clear();
  endtask

  task automatic test_cold_miss();
    do_access(32'h0, 1'b0, -1, -1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs[0] = 32'h4; pcs[1] = 32'h8; pcs[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      bus.if_req_i = 1'b1;
      bus.if_pc_i  = pcs[i];
      step();
      vectors++;
      if (bus.inst_vld_o !== 1'b1 || bus.inst_o !== mem_word(pcs[i])) begin
        miscompares++;
        $display("[TB] FAIL stream %0d: vld=%b inst=%h, need 1 %h",
                 i, bus.inst_vld_o, bus.inst_o, mem_word(pcs[i]));
      end
    end
    bus.if_req_i = 1'b0;
    step();
    vectors++;
    if (bus.inst_vld_o !== 1'b0 || bus.inst_o !== mem_word(32'hC)) begin
      miscompares++;
      $display("[TB] FAIL idle_hold: vld=%b inst=%h, need 0 %h",
               bus.inst_vld_o, bus.inst_o, mem_word(32'hC));
    end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    vectors++;
    if (hit_cnt !== 32'd4 || miss_cnt !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL perf_counts: hit=%0d miss=%0d, need 4 1", hit_cnt, miss_cnt);
    end
  endtask
`endif

  task automatic test_conflict();
    do_access(32'h400, 1'b0, -1, -1);
    do_access(32'h0, 1'b0, -1, -1);
  endtask

  task automatic test_flush_refill();
    do_access(32'h4, 1'b0, -1, -1);
    do_access(32'h18, 1'b0, 2, -1);
    do_access(32'h8, 1'b0, -1, -1);
  endtask

  task automatic test_flush_idle();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    model_clear();
    vectors++;
    if (bus.inst_vld_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_idle: vld=%b stall=%b, need 0 0", bus.inst_vld_o, bus.stall_o);
    end
    do_access(32'h8, 1'b0, -1, -1);
    do_access(32'hC, 1'b1, -1, -1);
  endtask

  task automatic test_stalled_acks();
    do_access(32'h2C, 1'b0, -1, 5);
    for (int w = 0; w < WORDS; w++) do_access(32'h20 + 32'(4 * w), 1'b0, -1, -1);
  endtask

  task automatic test_idle_ack_noise();
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = $urandom;
      step();
      bus.mem_ack_i = 1'b0;
      vectors++;
      if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.inst_vld_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_ack: req=%b stall=%b vld=%b, need 0 0 0",
                 bus.mem_req_o, bus.stall_o, bus.inst_vld_o);
      end
    end
    do_access(32'h24, 1'b0, -1, -1);
  endtask

  task automatic test_reset_mid_refill();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    model_clear();
    bus.if_req_i = 1'b1;
    bus.if_pc_i  = 32'h2000;
    step();
    bus.if_req_i = 1'b0;
    vectors++;
    if (bus.mem_req_o !== 1'b1 || bus.stall_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_miss: req=%b stall=%b, need 1 1", bus.mem_req_o, bus.stall_o);
    end
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = mem_word(32'h2000);
    step();
    bus.mem_ack_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.inst_vld_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: req=%b stall=%b vld=%b, need 0 0 0",
               bus.mem_req_o, bus.stall_o, bus.inst_vld_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    model_clear();
    do_access(32'h0, 1'b0, -1, -1);
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int i = 0; i < 80; i++) begin
      pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      do_access(pc, ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1, -1);
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  initial begin
    bus.if_req_i   = 1'b0;
    bus.if_pc_i    = 32'h0;
    bus.flush_i    = 1'b0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = 32'h0;
    for (int w = 0; w < WORDS; w++) begin
      mem_img[32'(4 * w)]          = 32'hA0 + 32'(w);
      mem_img[32'h400 + 32'(4 * w)] = 32'hB0 + 32'(w);
    end
    model_clear();
    test_reset();
    test_cold_miss();
    test_back_to_back();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    test_conflict();
    test_flush_refill();
    test_flush_idle();
    test_stalled_acks();
    test_idle_ack_noise();
    test_reset_mid_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
